// File: rtl/mult_radix4_pkg.sv
// ============================================================================
// Module      : mult_radix4_pkg
// Description : Shared types and helpers for the radix-4 iterative multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_radix4_pkg;

    // Bits per radix-4 digit
    localparam int DIGIT_W = 2;

    // Multiplier controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of radix-4 digits in an operand of the given width
    function automatic int digit_count(input int width);
        return width / DIGIT_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_radix4_iter_mul2x2_digit.sv
// ============================================================================
// Module      : mul2x2_digit
// Description : Combinational 2-bit x 2-bit unsigned multiplier (4-bit result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul2x2_digit (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output logic [3:0] o_p
);

    // Zero-extend before multiplying so the full 4-bit product is kept
    assign o_p = {2'b00, i_a} * {2'b00, i_b};

endmodule

`default_nettype wire

// File: rtl/mult_radix4_iter.sv
// ============================================================================
// Module      : mult_radix4_iter
// Description : Iterative unsigned multiplier. One radix-4 digit of B is
//               processed per cycle against all digits of A in parallel;
//               valid/ready handshakes on input and output.
//               Optional macro MULT_RADIX4_EARLY_TERM_EN ends the RUN phase
//               as soon as the remaining B digits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_radix4_iter
    import mult_radix4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    localparam int DIGITS = digit_count(WIDTH);
    localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW     = 2 * WIDTH;

    // Reject widths that do not split into whole radix-4 digits
    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("mult_radix4_iter: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      p_q, p_d;

    logic [WIDTH-1:0]   b_shift;
    logic [1:0]         b_dig;
    logic [3:0]         pp [DIGITS];
    logic [PW-1:0]      row;
    logic [PW-1:0]      acc_sum;
    logic               last_digit;

    // Current B digit selected by the digit counter
    assign b_shift = b_q >> (DIGIT_W * k_q);
    assign b_dig   = b_shift[1:0];

    // One 2x2 digit multiplier per A digit, all sharing the current B digit
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            mul2x2_digit u_mul (
                .i_a (a_q[DIGIT_W*gi +: DIGIT_W]),
                .i_b (b_dig),
                .o_p (pp[gi])
            );
        end
    endgenerate

    // Combine the digit products into one row aligned to A's digit positions
    always_comb begin
        row = '0;
        for (int i = 0; i < DIGITS; i++) begin
            row = row + ({{(PW-4){1'b0}}, pp[i]} << (DIGIT_W * i));
        end
    end

    assign acc_sum = acc_q + (row << (DIGIT_W * k_q));

`ifdef MULT_RADIX4_EARLY_TERM_EN
    logic [WIDTH-1:0] b_rest;
    // Remaining (not yet processed) B digits; all zero means nothing left to add
    assign b_rest     = b_q >> (DIGIT_W * (k_q + 1));
    assign last_digit = (k_q == KW'(DIGITS - 1)) || (b_rest == '0);
`else
    assign last_digit = (k_q == KW'(DIGITS - 1));
`endif

    // Next-state, datapath load and accumulation decisions
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                if (last_digit) begin
                    p_d     = acc_sum;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign P         = p_q;

endmodule

`default_nettype wire
